// File: rtl/counter_inc_feeder.sv
// counter_inc_feeder
//   Upstream stage of the Counter block. Increment requests arrive over a
//   valid/ready handshake and are buffered in a small FIFO. At most one request
//   per cycle is drained onto the Counter's registered io_inc/io_amt inputs.
//   A shadow running total (io_exp_tot) is kept so a checker can compare it
//   against the Counter's io_tot, which lags it by one cycle.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous reset, active-low (0 = reset)
//   io_in_valid  request present
//   io_in_amt    request amount
//   io_in_ready  FIFO can accept this cycle (forced 0 while reset is low)
//   io_drain_en  permits a pop this cycle
//   io_inc       registered increment strobe to the Counter
//   io_amt       registered increment amount to the Counter
//   io_count     FIFO occupancy, 0..DEPTH
//   io_exp_tot   shadow total of all issued amounts, modulo 2^TOT_W
//   io_wrap      sticky flag, set when io_exp_tot wraps
//
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.

module counter_inc_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AMT_W = 4,
  parameter int unsigned TOT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_in_valid,
  input  logic [AMT_W-1:0]         io_in_amt,
  output logic                     io_in_ready,
  input  logic                     io_drain_en,
  output logic                     io_inc,
  output logic [AMT_W-1:0]         io_amt,
  output logic [$clog2(DEPTH):0]   io_count,
  output logic [TOT_W-1:0]         io_exp_tot,
  output logic                     io_wrap
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = TOT_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [AMT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inc_q, inc_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             wrap_q, wrap_d;

  logic             push;
  logic             pop;
  logic [AMT_W-1:0] head;
  logic [SUM_W-1:0] sum;

  // Ready depends on the reset pin directly so no handshake can complete
  // during a reset cycle.
  assign io_in_ready = reset && (count_q != FULL_CNT);

  assign push = io_in_valid && io_in_ready;
  assign pop  = io_drain_en && (count_q != '0);
  assign head = mem_q[rd_ptr_q];

  // One extra bit catches the carry out of the shadow total.
  assign sum = {1'b0, tot_q} + SUM_W'(head);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    inc_d    = 1'b0;
    amt_d    = '0;
    tot_d    = tot_q;
    wrap_d   = wrap_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    // Pop only sees entries written at earlier edges: no bypass path.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      inc_d    = 1'b1;
      amt_d    = head;
      tot_d    = sum[TOT_W-1:0];
      if (sum[TOT_W]) begin
        wrap_d = 1'b1;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      inc_q    <= 1'b0;
      amt_q    <= '0;
      tot_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      inc_q    <= inc_d;
      amt_q    <= amt_d;
      tot_q    <= tot_d;
      wrap_q   <= wrap_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  // push is already qualified by reset through io_in_ready.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= io_in_amt;
    end
  end

  assign io_inc     = inc_q;
  assign io_amt     = amt_q;
  assign io_count   = count_q;
  assign io_exp_tot = tot_q;
  assign io_wrap    = wrap_q;

endmodule

// File: tb/tb_counter_inc_feeder.sv
// Testbench for counter_inc_feeder: directed vectors plus a random soak.
// Accepted requests are queued as expected issues; an independent monitor
// pops and compares on every io_inc, tracks the expected shadow total/wrap,
// and models the downstream Counter to confirm io_tot trails io_exp_tot.

module tb_counter_inc_feeder;

  logic       clk;
  logic       reset;
  logic       io_in_valid;
  logic [3:0] io_in_amt;
  logic       io_in_ready;
  logic       io_drain_en;
  logic       io_inc;
  logic [3:0] io_amt;
  logic [2:0] io_count;
  logic [7:0] io_exp_tot;
  logic       io_wrap;

  counter_inc_feeder #(.DEPTH(4), .AMT_W(4), .TOT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_amt   (io_in_amt),
    .io_in_ready (io_in_ready),
    .io_drain_en (io_drain_en),
    .io_inc      (io_inc),
    .io_amt      (io_amt),
    .io_count    (io_count),
    .io_exp_tot  (io_exp_tot),
    .io_wrap     (io_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned sb_q[$];
  int unsigned tot_m   = 0;
  bit          wrap_m  = 0;
  int unsigned ctr_tot = 0;
  int unsigned prev_exp = 0;
  bit          have_prev = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted; record the expected issue.
  task automatic send(input int unsigned a);
    bit got;
    got = 0;
    io_in_valid = 1'b1;
    io_in_amt   = a[3:0];
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (io_in_ready) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      sb_q.push_back(a);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout actual=not_ready expected=accept amt=%0d", a);
    end
    @(posedge clk);
    #1;
    io_in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
  endtask

  // Reset flush of the expectations and the downstream Counter model.
  always @(posedge clk) begin
    if (!reset) begin
      sb_q.delete();
      tot_m     = 0;
      wrap_m    = 0;
      ctr_tot   = 0;
      have_prev = 0;
    end else if (io_inc) begin
      ctr_tot = (ctr_tot + int'(io_amt)) % 256;
    end
  end

  always @(negedge clk) begin
    int unsigned exp_a;
    if (io_inc) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_unexpected actual_amt=%0d expected=no_issue", io_amt);
      end else begin
        exp_a = sb_q.pop_front();
        check("issue_amt", io_amt, exp_a);
        tot_m = tot_m + exp_a;
        if (tot_m > 255) begin
          tot_m  = tot_m - 256;
          wrap_m = 1;
        end
        check("exp_tot", io_exp_tot, tot_m);
        check("wrap", io_wrap, wrap_m);
      end
    end
    if (have_prev) check("ctr_tot_lag", ctr_tot, prev_exp);
    prev_exp  = io_exp_tot;
    have_prev = 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int zero_inc;
    reset       = 1'b0;
    io_in_valid = 1'b0;
    io_in_amt   = '0;
    io_drain_en = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_count", io_count, 0);
    check("rst_inc", io_inc, 0);
    check("rst_amt", io_amt, 0);
    check("rst_exp_tot", io_exp_tot, 0);
    check("rst_wrap", io_wrap, 0);
    check("rst_ready", io_in_ready, 0);
    reset = 1'b1;
    #1;
    check("ready_after_rst", io_in_ready, 1);

    // Single request, latency of two edges
    io_drain_en = 1'b1;
    send(5);
    check("t1_count_after_push", io_count, 1);
    check("t1_no_bypass", io_inc, 0);
    step();
    check("t1_inc", io_inc, 1);
    check("t1_amt", io_amt, 5);
    check("t1_exp_tot", io_exp_tot, 5);
    step();
    check("t1_inc_one_cycle", io_inc, 0);
    check("t1_count_empty", io_count, 0);
    step();

    // Fill, hold off a fifth request, then drain
    apply_reset();
    io_drain_en = 1'b0;
    send(1); send(2); send(3); send(4);
    check("t2_count_full", io_count, 4);
    check("t2_ready_full", io_in_ready, 0);
    io_in_valid = 1'b1;
    io_in_amt   = 4'd9;
    repeat (3) begin
      step();
      check("t2_held_ready", io_in_ready, 0);
      check("t2_held_count", io_count, 4);
      check("t2_held_inc", io_inc, 0);
    end
    io_drain_en = 1'b1;
    @(negedge clk);
    check("t2_ready_not_same_cycle", io_in_ready, 0);
    send(9);
    repeat (8) step();
    check("t2_final_tot", io_exp_tot, 19);
    check("t2_final_count", io_count, 0);

    // Back-to-back 15s through the wrap
    apply_reset();
    io_drain_en = 1'b1;
    n = 0;
    fork
      begin
        repeat (18) send(15);
      end
      begin
        for (int i = 0; i < 60; i++) begin
          step();
          if (io_inc) begin
            n++;
            if (n == 5) begin
              check("t3_steady_count", io_count, 1);
              check("t3_steady_ready", io_in_ready, 1);
            end
            if (n == 17) begin
              check("t3_tot_17", io_exp_tot, 255);
              check("t3_wrap_17", io_wrap, 0);
            end
            if (n == 18) begin
              check("t3_tot_18", io_exp_tot, 14);
              check("t3_wrap_18", io_wrap, 1);
              break;
            end
          end
        end
      end
    join
    check("t3_issue_count", n, 18);
    repeat (3) step();
    check("t3_wrap_sticky", io_wrap, 1);

    // Zero-amount requests
    apply_reset();
    io_drain_en = 1'b1;
    zero_inc = 0;
    fork
      begin
        send(0);
        send(0);
      end
      begin
        repeat (8) begin
          step();
          if (io_inc && io_amt == 4'd0) zero_inc++;
        end
      end
    join
    check("t4_zero_issues", zero_inc, 2);
    check("t4_tot_unchanged", io_exp_tot, 0);

    // Reset in the middle of a drain
    apply_reset();
    io_drain_en = 1'b0;
    send(3); send(5); send(7);
    check("t5_count_3", io_count, 3);
    io_drain_en = 1'b1;
    step();
    check("t5_draining", io_inc, 1);
    reset = 1'b0;
    #1;
    check("t5_ready_in_reset", io_in_ready, 0);
    step();
    check("t5_count", io_count, 0);
    check("t5_inc", io_inc, 0);
    check("t5_exp_tot", io_exp_tot, 0);
    check("t5_wrap", io_wrap, 0);
    reset = 1'b1;
    #1;
    check("t5_ready_after", io_in_ready, 1);
    io_drain_en = 1'b0;
    step();
    check("t5_discarded", io_count, 0);

    // Random soak
    for (int c = 0; c < 2000; c++) begin
      io_in_valid = ($urandom_range(0, 1) == 1);
      io_in_amt   = 4'($urandom_range(0, 15));
      io_drain_en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (io_in_valid && io_in_ready) sb_q.push_back(int'(io_in_amt));
      @(posedge clk);
      #1;
    end
    io_in_valid = 1'b0;
    io_drain_en = 1'b1;
    repeat (8) step();
    check("t6_all_issued", sb_q.size(), 0);
    check("t6_count_empty", io_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_inc_feeder.md
Name: counter_inc_feeder

Overview:
- Upstream stage of the Counter block. Accepts increment requests over a valid/ready handshake and buffers them in a small FIFO.
- Drains at most one request per cycle onto the Counter's io_inc/io_amt inputs.
- Keeps a shadow running total (io_exp_tot), so a checker can compare it against the Counter's io_tot.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AMT_W, 4, width of increment amount; matches Counter io_amt.
- TOT_W, 8, width of shadow total; matches Counter io_tot.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- io_in_valid  input  1  request present.
- io_in_amt  input  AMT_W  request amount.
- io_in_ready  output  1  FIFO can accept this cycle.
- io_drain_en  input  1  permits a pop this cycle; 0 stalls the Counter feed.
- io_inc  output  1  registered; drives Counter io_inc.
- io_amt  output  AMT_W  registered; drives Counter io_amt.
- io_count  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- io_exp_tot  output  TOT_W  shadow total of all amounts issued.
- io_wrap  output  1  sticky; set when io_exp_tot wraps.

Behaviour:
- Reset (reset==0 at a rising edge):
  - rd/wr pointers and io_count go to 0.
  - io_inc=0, io_amt=0, io_exp_tot=0, io_wrap=0.
  - io_in_ready is forced to 0 combinationally while reset==0.
  - An in-flight handshake is dropped and FIFO contents are discarded.
- io_in_ready = reset && (io_count != DEPTH).
- Push: io_in_valid && io_in_ready at an edge writes io_in_amt at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop condition, evaluated on pre-edge state: io_drain_en && (io_count != 0).
  - When pop is true at an edge: io_inc<=1, io_amt<=FIFO[rd_ptr], rd_ptr increments modulo DEPTH, io_exp_tot<=(io_exp_tot+FIFO[rd_ptr]) mod 2^TOT_W.
  - If the addition carries out of TOT_W, io_wrap<=1. It stays 1 until reset.
  - Otherwise: io_inc<=0, io_amt<=0, io_exp_tot and io_wrap hold.
- No bypass. A request pushed at edge k is popped at edge k+1 at the earliest, so io_inc=1 is visible in the cycle after edge k+1 (2-cycle accept-to-issue latency).
- Simultaneous push and pop with 0<count<DEPTH: both occur and count is unchanged.
- Empty plus push: no pop this edge; count becomes 1.
- Full: io_in_ready=0, so no push. A pop at that edge frees a slot, and ready rises in the following cycle, not the same one.
- io_count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Zero-amount requests are queued and issued normally: io_inc=1, io_amt=0, io_exp_tot unchanged.
- Ordering is strict FIFO; no reordering and no coalescing.
- io_exp_tot leads Counter io_tot by one cycle: the Counter adds io_amt at the edge after io_inc is seen.
- io_in_amt is ignored when io_in_valid=0. Stable inputs are not required while not ready.

Test Plan:
- Reset, then push a single amt=5 with drain_en=1:
  - Accepted at edge k.
  - io_inc=1 and io_amt=5 after edge k+1, for exactly one cycle.
  - io_exp_tot=5; one cycle later Counter io_tot=5.
- drain_en=0, push amounts 1,2,3,4:
  - io_count reaches 4 and io_in_ready=0; a 5th valid (amt 9) is held off.
  - Raise drain_en: issues 1,2,3,4 in order on consecutive cycles, then the held 9 is accepted.
  - Final io_exp_tot=19.
- Continuous valid with amt=15 and drain_en=1:
  - Steady state is one push and one pop per cycle with io_count=1.
  - After 17 issues io_exp_tot=255 and io_wrap=0.
  - The 18th issue gives io_exp_tot=14 and io_wrap=1, which stays 1.
- Push amt=0 twice with drain_en=1 → two cycles of io_inc=1, io_amt=0; io_exp_tot unchanged.
- Fill 3 entries, then pull reset=0 for one cycle mid-drain:
  - Next cycle io_count=0, io_inc=0, io_exp_tot=0, io_wrap=0.
  - io_in_ready=0 during the reset cycle and 1 after it.
- Random valid/drain_en for 2000 cycles: every accepted amount is issued exactly once, in order, and io_exp_tot always equals the Counter's io_tot one cycle later.
